// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported synchronous memory.
// Data has priority; a bounded streak counter guarantees fetch forward progress.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  // data port
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // control / status
  input  logic          halted,
  output logic          busy,
  output logic [15:0]   if_cnt,
  output logic [15:0]   dm_cnt
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t          state_q, state_d;
  owner_t          owner_q;
  logic [SW-1:0]   streak_q;
  logic [DW-1:0]   if_hold_q, dm_hold_q;
  logic            fetch_elig, data_elig;
  logic            fetch_win, data_win;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fetch_win || (data_win && !dm_we)) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // arbitration and outputs; grants are gated by rst_n so nothing is granted while held in reset
  always_comb begin
    fetch_elig = if_req && !halted;
    data_elig  = dm_req;
    fetch_win  = 1'b0;
    data_win   = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (fetch_elig && (!data_elig || streak_q == STREAK_MAX)) fetch_win = 1'b1;
      else if (data_elig)                                        data_win  = 1'b1;
    end
    if_gnt    = fetch_win;
    dm_gnt    = data_win;
    mem_en    = fetch_win || data_win;
    mem_we    = data_win && dm_we;
    mem_addr  = data_win ? dm_addr : if_addr;
    mem_wdata = data_win ? dm_wdata : '0;
    busy      = (state_q == RESP);
    if_rvalid = busy && (owner_q == OWN_IF);
    dm_rvalid = busy && (owner_q == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : if_hold_q;
    dm_rdata  = dm_rvalid ? mem_rdata : dm_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_IF;
      streak_q  <= '0;
      if_cnt    <= '0;
      dm_cnt    <= '0;
      if_hold_q <= '0;
      dm_hold_q <= '0;
    end else begin
      if (fetch_win)                 owner_q <= OWN_IF;
      else if (data_win && !dm_we)   owner_q <= OWN_DM;

      // streak only grows while fetch is actually being passed over
      if (fetch_win || !fetch_elig)                    streak_q <= '0;
      else if (data_win && streak_q != STREAK_MAX)     streak_q <= streak_q + 1'b1;

      if (fetch_win && if_cnt != '1) if_cnt <= if_cnt + 16'd1;
      if (data_win  && dm_cnt != '1) dm_cnt <= dm_cnt + 16'd1;

      if (if_rvalid) if_hold_q <= mem_rdata;
      if (dm_rvalid) dm_hold_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: memory model, read scoreboard and per-feature tasks.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, dm_we, halted;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   if_cnt, dm_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          port;   // 0 = fetch, 1 = data
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .halted(halted), .busy(busy), .if_cnt(if_cnt), .dm_cnt(dm_cnt)
  );

  always #5 clk = ~clk;

  // synchronous memory model: read data one clock after a read enable
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i * 3 + 1);
    mem[120] = 32'd85;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata     <= mem[mem_addr];
      end
    end
  end

  // scoreboard: pushes on observed read grants (data from the bench's own reference), pops on rvalid
  initial begin : monitor
    exp_t          e;
    logic [DW-1:0] last_if, last_dm;
    for (int i = 0; i < 1024; i++) ref_mem[i] = DW'(i * 3 + 1);
    ref_mem[120] = 32'd85;
    last_if = '0;
    last_dm = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        last_if = '0;
        last_dm = '0;
      end else begin
        if (if_rvalid || dm_rvalid) begin
          checks++;
          if (if_rvalid && dm_rvalid) begin
            errors++;
            $display("FAIL both_rvalid: if_rvalid=%b dm_rvalid=%b, required at most one", if_rvalid, dm_rvalid);
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid: if_rvalid=%b dm_rvalid=%b with no read outstanding", if_rvalid, dm_rvalid);
          end else begin
            e = exp_q.pop_front();
            if (e.port !== dm_rvalid) begin
              errors++;
              $display("FAIL rvalid_port: got dm_rvalid=%b, required %b", dm_rvalid, e.port);
            end else if ((dm_rvalid ? dm_rdata : if_rdata) !== e.data) begin
              errors++;
              $display("FAIL rdata: got %h, required %h (port %b)", dm_rvalid ? dm_rdata : if_rdata, e.data, e.port);
            end
            if (e.port) last_dm = e.data;
            else        last_if = e.data;
          end
        end else begin
          checks++;
          if (if_rdata !== last_if || dm_rdata !== last_dm) begin
            errors++;
            $display("FAIL rdata_hold: if_rdata=%h dm_rdata=%h, required %h %h", if_rdata, dm_rdata, last_if, last_dm);
          end
        end
        if (if_gnt) begin
          e.port = 1'b0; e.data = ref_mem[if_addr];
          exp_q.push_back(e);
        end
        if (dm_gnt) begin
          if (dm_we) ref_mem[dm_addr] = dm_wdata;
          else begin
            e.port = 1'b1; e.data = ref_mem[dm_addr];
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; halted = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    if_req = 1'b1; dm_req = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, mem_en} !== 6'b0 ||
        if_cnt !== 16'd0 || dm_cnt !== 16'd0 || if_rdata !== '0 || dm_rdata !== '0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b%b rv=%b%b busy=%b en=%b cnt=%0d/%0d rdata=%h/%h, required all zero",
               if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, mem_en, if_cnt, dm_cnt, if_rdata, dm_rdata);
    end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
        mem_addr !== 10'd120 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_grant: dm_gnt=%b if_gnt=%b en=%b we=%b addr=%0d busy=%b, required 1 0 1 0 120 0",
               dm_gnt, if_gnt, mem_en, mem_we, mem_addr, busy);
    end
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    checks++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== 32'd85 || busy !== 1'b1 || dm_gnt !== 1'b0) begin
      errors++;
      $display("FAIL read_resp: dm_rvalid=%b dm_rdata=%0d busy=%b dm_gnt=%b, required 1 85 1 0",
               dm_rvalid, dm_rdata, busy, dm_gnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dm_rvalid !== 1'b0 || dm_rdata !== 32'd85) begin
      errors++;
      $display("FAIL read_after: busy=%b dm_rvalid=%b dm_rdata=%0d, required 0 0 85", busy, dm_rvalid, dm_rdata);
    end
    tick();
  endtask

  task automatic test_write_read();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd121; dm_wdata = 32'd130;
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'd130 || mem_addr !== 10'd121) begin
      errors++;
      $display("FAIL write_grant: dm_gnt=%b we=%b wdata=%0d addr=%0d, required 1 1 130 121",
               dm_gnt, mem_we, mem_wdata, mem_addr);
    end
    tick();
    dm_we = 1'b0; dm_wdata = '0;
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1 || dm_rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_then_read_grant: dm_gnt=%b dm_rvalid=%b busy=%b, required 1 0 0", dm_gnt, dm_rvalid, busy);
    end
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    checks++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== 32'd130) begin
      errors++;
      $display("FAIL write_readback: dm_rvalid=%b dm_rdata=%0d, required 1 130", dm_rvalid, dm_rdata);
    end
    tick();
  endtask

  task automatic test_streak();
    logic [9:0] seq;
    int         g;
    seq = 10'b10_0001_0000;
    pulse_reset();
    if_req = 1'b1; if_addr = 10'd200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd300;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (c % 2 == 0) begin
        g = c / 2;
        if (if_gnt !== seq[g] || dm_gnt !== !seq[g] || mem_addr !== (seq[g] ? 10'd200 : 10'd300)) begin
          errors++;
          $display("FAIL streak_order: grant %0d if_gnt=%b dm_gnt=%b addr=%0d, required fetch=%b",
                   g, if_gnt, dm_gnt, mem_addr, seq[g]);
        end
      end else if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL streak_resp: cycle %0d gnt=%b%b busy=%b, required 00 1", c, if_gnt, dm_gnt, busy);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (if_cnt !== 16'd2 || dm_cnt !== 16'd8) begin
      errors++;
      $display("FAIL streak_counts: if_cnt=%0d dm_cnt=%0d, required 2 8", if_cnt, dm_cnt);
    end
    tick();
  endtask

  task automatic test_halted();
    halted = 1'b1; if_req = 1'b1; if_addr = 10'd55;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || mem_en !== 1'b0) begin
        errors++;
        $display("FAIL halted_block: cycle %0d if_gnt=%b mem_en=%b, required 0 0", c, if_gnt, mem_en);
      end
      tick();
    end
    halted = 1'b0;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 10'd55 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL halted_release: if_gnt=%b addr=%0d we=%b, required 1 55 0", if_gnt, mem_addr, mem_we);
    end
    tick();
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_halt_during_resp();
    if_req = 1'b1; if_addr = 10'd77;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL halt_resp_grant: if_gnt=%b, required 1", if_gnt);
    end
    tick();
    if_req = 1'b0; halted = 1'b1;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'd232) begin
      errors++;
      $display("FAIL halt_resp_rvalid: if_rvalid=%b if_rdata=%0d, required 1 232", if_rvalid, if_rdata);
    end
    tick();
    halted = 1'b0;
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = AW'(400 + i); dm_wdata = DW'(32'hA0 + i);
      @(negedge clk);
      checks++;
      if (dm_gnt !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== DW'(32'hA0 + i)) begin
        errors++;
        $display("FAIL b2b_write: beat %0d dm_gnt=%b busy=%b we=%b wdata=%h, required 1 0 1 %h",
                 i, dm_gnt, busy, mem_we, mem_wdata, 32'hA0 + i);
      end
      tick();
    end
    idle_inputs();
    if_req = 1'b1; if_addr = 10'd402;
    @(negedge clk);
    checks++;
    if (dm_cnt !== 16'd4 || if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: dm_cnt=%0d if_gnt=%b, required 4 1", dm_cnt, if_gnt);
    end
    tick();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hA2) begin
      errors++;
      $display("FAIL b2b_readback: if_rvalid=%b if_rdata=%h, required 1 a2", if_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_reset_in_resp();
    if_req = 1'b1; if_addr = 10'd9;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_resp_grant: if_gnt=%b, required 1", if_gnt);
    end
    tick();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0 || if_gnt !== 1'b0 || busy !== 1'b0 || if_cnt !== 16'd0 || dm_cnt !== 16'd0) begin
        errors++;
        $display("FAIL rst_resp_hold: if_rvalid=%b if_gnt=%b busy=%b cnt=%0d/%0d, required 0 0 0 0/0",
                 if_rvalid, if_gnt, busy, if_cnt, dm_cnt);
      end
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || if_rvalid !== 1'b0 || if_cnt !== 16'd0 || if_rdata !== '0) begin
      errors++;
      $display("FAIL rst_resp_first_grant: if_gnt=%b if_rvalid=%b if_cnt=%0d if_rdata=%h, required 1 0 0 0",
               if_gnt, if_rvalid, if_cnt, if_rdata);
    end
    tick();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'd28) begin
      errors++;
      $display("FAIL rst_resp_reissue: if_rvalid=%b if_rdata=%0d, required 1 28", if_rvalid, if_rdata);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_read();
    test_streak();
    test_halted();
    test_halt_during_resp();
    test_back_to_back();
    test_reset_in_resp();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_reads: %0d responses never returned, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
